// File: rtl/queue.sv
// Circular-buffer FIFO with registered DATA_OUT, FULL, EMPTY and COUNT.
// Define QUEUE_ERR_EN to build the sticky overflow/underflow ERR flag; otherwise ERR is tied low.
module queue #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     PUSH,
    input  logic                     POP,
    input  logic [DATA_WIDTH-1:0]    DATA_IN,
    output logic [DATA_WIDTH-1:0]    DATA_OUT,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     ERR
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr;
    logic [PTR_W-1:0]      rd;
    logic [PTR_W-1:0]      wr_next;
    logic [PTR_W-1:0]      rd_next;
    logic [CNT_W-1:0]      count_next;
    logic                  push_ok;
    logic                  pop_ok;

    // Accept decisions use the registered flags, so upstream sees a stable view.
    assign push_ok = PUSH & ~FULL;
    assign pop_ok  = POP & ~EMPTY;

    // Explicit wrap compare keeps non-power-of-two depths correct.
    assign wr_next = (wr == PTR_W'(DEPTH - 1)) ? '0 : wr + 1'b1;
    assign rd_next = (rd == PTR_W'(DEPTH - 1)) ? '0 : rd + 1'b1;

    always_comb begin
        count_next = COUNT;
        case ({push_ok, pop_ok})
            2'b10:   count_next = COUNT + 1'b1;
            2'b01:   count_next = COUNT - 1'b1;
            default: count_next = COUNT;
        endcase
    end

    // Storage is deliberately left uninitialised by reset.
    always_ff @(posedge CLK) begin
        if (!RST && push_ok) begin
            mem[wr] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr       <= '0;
            rd       <= '0;
            COUNT    <= '0;
            DATA_OUT <= '0;
            FULL     <= 1'b0;
            EMPTY    <= 1'b1;
        end else begin
            if (push_ok) begin
                wr <= wr_next;
            end
            if (pop_ok) begin
                DATA_OUT <= mem[rd];
                rd       <= rd_next;
            end
            COUNT <= count_next;
            FULL  <= (count_next == CNT_W'(DEPTH));
            EMPTY <= (count_next == '0);
        end
    end

`ifdef QUEUE_ERR_EN
    // Any request against the wrong flag is sticky until reset, even if paired with a valid one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ERR <= 1'b0;
        end else if ((PUSH && FULL) || (POP && EMPTY)) begin
            ERR <= 1'b1;
        end
    end
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_queue.sv
// Directed self-checking bench for queue (DATA_WIDTH=8, DEPTH=4).
// ERR expectations follow QUEUE_ERR_EN so the bench works with either build.
module tb_queue;

    logic       CLK;
    logic       RST;
    logic       PUSH;
    logic       POP;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT;
    logic       FULL;
    logic       EMPTY;
    logic [2:0] COUNT;
    logic       ERR;

    int compared   = 0;
    int mismatched = 0;

`ifdef QUEUE_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    queue #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .PUSH     (PUSH),
        .POP      (POP),
        .DATA_IN  (DATA_IN),
        .DATA_OUT (DATA_OUT),
        .FULL     (FULL),
        .EMPTY    (EMPTY),
        .COUNT    (COUNT),
        .ERR      (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic rst, input logic push, input logic pop,
                                 input logic [7:0] din);
        RST     = rst;
        PUSH    = push;
        POP     = pop;
        DATA_IN = din;
        @(posedge CLK);
        #1;
        RST  = 1'b0;
        PUSH = 1'b0;
        POP  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        RST = 1'b0; PUSH = 1'b0; POP = 1'b0; DATA_IN = 8'h00;
        @(negedge CLK);

        // Reset state
        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("rst_count", 32'(COUNT), 0);
        checkOutput("rst_empty", 32'(EMPTY), 1);
        checkOutput("rst_full", 32'(FULL), 0);
        checkOutput("rst_dout", 32'(DATA_OUT), 0);
        checkOutput("rst_err", 32'(ERR), 0);

        // Fill
        applyStimulus(0, 1, 0, 8'h11);
        checkOutput("fill1_empty", 32'(EMPTY), 0);
        checkOutput("fill1_count", 32'(COUNT), 1);
        applyStimulus(0, 1, 0, 8'h22);
        applyStimulus(0, 1, 0, 8'h33);
        checkOutput("fill3_full", 32'(FULL), 0);
        applyStimulus(0, 1, 0, 8'h44);
        checkOutput("fill4_full", 32'(FULL), 1);
        checkOutput("fill4_count", 32'(COUNT), 4);

        // Overflow push
        applyStimulus(0, 1, 0, 8'h55);
        checkOutput("ovf_count", 32'(COUNT), 4);
        checkOutput("ovf_full", 32'(FULL), 1);
        checkOutput("ovf_err", 32'(ERR), 32'(ERR_EXP));

        // Drain
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("drain1_dout", 32'(DATA_OUT), 32'h11);
        checkOutput("drain1_full", 32'(FULL), 0);
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("drain2_dout", 32'(DATA_OUT), 32'h22);
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("drain3_dout", 32'(DATA_OUT), 32'h33);
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("drain4_dout", 32'(DATA_OUT), 32'h44);
        checkOutput("drain4_empty", 32'(EMPTY), 1);
        checkOutput("drain4_count", 32'(COUNT), 0);
        checkOutput("drain_err_sticky", 32'(ERR), 32'(ERR_EXP));

        // Underflow pop
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("unf_dout", 32'(DATA_OUT), 32'h44);
        checkOutput("unf_count", 32'(COUNT), 0);
        checkOutput("unf_empty", 32'(EMPTY), 1);
        checkOutput("unf_err", 32'(ERR), 32'(ERR_EXP));

        // Wrap-around with alternating push/pop
        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("rst2_err", 32'(ERR), 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 8'(i));
            checkOutput("wrap_push_count", 32'(COUNT), 1);
            applyStimulus(0, 0, 1, 8'h00);
            checkOutput("wrap_pop_dout", 32'(DATA_OUT), 32'(i));
            checkOutput("wrap_pop_count", 32'(COUNT), 0);
        end

        // Simultaneous push/pop in the middle
        applyStimulus(0, 1, 0, 8'hA0);
        applyStimulus(0, 1, 0, 8'hA1);
        applyStimulus(0, 1, 1, 8'hB0);
        checkOutput("sim_dout", 32'(DATA_OUT), 32'hA0);
        checkOutput("sim_count", 32'(COUNT), 2);
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("sim_pop1", 32'(DATA_OUT), 32'hA1);
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("sim_pop2", 32'(DATA_OUT), 32'hB0);
        checkOutput("sim_empty", 32'(EMPTY), 1);
        checkOutput("sim_err", 32'(ERR), 0);

        // Simultaneous push/pop while full: push dropped
        applyStimulus(0, 1, 0, 8'hC0);
        applyStimulus(0, 1, 0, 8'hC1);
        applyStimulus(0, 1, 0, 8'hC2);
        applyStimulus(0, 1, 0, 8'hC3);
        checkOutput("fullsim_pre_full", 32'(FULL), 1);
        applyStimulus(0, 1, 1, 8'hFF);
        checkOutput("fullsim_dout", 32'(DATA_OUT), 32'hC0);
        checkOutput("fullsim_count", 32'(COUNT), 3);
        checkOutput("fullsim_full", 32'(FULL), 0);
        checkOutput("fullsim_err", 32'(ERR), 32'(ERR_EXP));
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("fullsim_pop1", 32'(DATA_OUT), 32'hC1);
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("fullsim_pop2", 32'(DATA_OUT), 32'hC2);
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("fullsim_pop3", 32'(DATA_OUT), 32'hC3);
        checkOutput("fullsim_empty", 32'(EMPTY), 1);
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("fullsim_noff", 32'(DATA_OUT), 32'hC3);

        // Simultaneous push/pop while empty: pop dropped, no bypass
        applyStimulus(0, 1, 1, 8'h77);
        checkOutput("emptysim_count", 32'(COUNT), 1);
        checkOutput("emptysim_dout", 32'(DATA_OUT), 32'hC3);
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("emptysim_pop", 32'(DATA_OUT), 32'h77);

        // Reset mid-operation together with a push
        applyStimulus(0, 1, 0, 8'hD0);
        applyStimulus(0, 1, 0, 8'hD1);
        applyStimulus(0, 1, 0, 8'hD2);
        checkOutput("mid_count", 32'(COUNT), 3);
        applyStimulus(1, 1, 0, 8'hDA);
        checkOutput("midrst_count", 32'(COUNT), 0);
        checkOutput("midrst_empty", 32'(EMPTY), 1);
        checkOutput("midrst_full", 32'(FULL), 0);
        checkOutput("midrst_dout", 32'(DATA_OUT), 0);
        checkOutput("midrst_err", 32'(ERR), 0);
        applyStimulus(0, 1, 0, 8'h5A);
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("post_rst_pop", 32'(DATA_OUT), 32'h5A);
        checkOutput("post_rst_empty", 32'(EMPTY), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/queue.md
# queue

First-in/first-out companion to the `stack` block: same PUSH/POP/FULL/EMPTY interface, but POP returns the oldest stored word. It buffers words between a producer and a slower consumer, e.g. the command path feeding the display/decode logic. It is a circular buffer with registered output, registered flags and an occupancy count. All state is held in one clock domain.

## Interface
- `DATA_WIDTH`, default 8: width of each stored word.
- `DEPTH`, default 4: number of entries; any value ≥ 2, power of two not required.
- `CLK`  input  1  clock; all state updates on the rising edge.
- `RST`  input  1  synchronous reset, active-high; one clock; reset is synchronous and active-high.
- `PUSH`  input  1  write request for `DATA_IN` this cycle.
- `POP`  input  1  read request for the oldest entry this cycle.
- `DATA_IN`  input  DATA_WIDTH  word to write.
- `DATA_OUT`  output  DATA_WIDTH  registered; last popped word.
- `FULL`  output  1  registered; COUNT == DEPTH.
- `EMPTY`  output  1  registered; COUNT == 0.
- `COUNT`  output  clog2(DEPTH)+1  registered occupancy, 0..DEPTH.
- `ERR`  output  1  sticky overflow/underflow flag (see Configuration).

## Operation
- State: storage array [DEPTH], write pointer `wr`, read pointer `rd`, both 0..DEPTH-1, plus COUNT.
- Reset (RST=1 at edge): `wr`=0, `rd`=0, COUNT=0, DATA_OUT=0, FULL=0, EMPTY=1, ERR=0. Storage contents are not cleared. Reset overrides any PUSH/POP in the same cycle.
- Accept conditions are evaluated on the registered flags:
  - push_ok = PUSH & !FULL
  - pop_ok = POP & !EMPTY
- push_ok: mem[wr] <= DATA_IN; `wr` advances.
- pop_ok: DATA_OUT <= mem[rd]; `rd` advances.
- Pointer advance: `wr`/`rd` go to ptr+1, wrapping from DEPTH-1 to 0 by explicit compare, not modulo power of two.
- COUNT update: +1 on push only; -1 on pop only; unchanged on both or neither.
- FULL and EMPTY are recomputed from the next COUNT in the same edge.
- Simultaneous PUSH and POP:
  - Neither full nor empty: both are performed; COUNT is unchanged; DATA_OUT gets the old head.
  - Full: only the pop is performed; the push is dropped.
  - Empty: only the push is performed; the pop is dropped. There is no write-through bypass, so DATA_OUT holds its value.
- Dropped request (push while FULL, or pop while EMPTY): no state change other than ERR when enabled.
- DATA_OUT holds its value whenever no pop_ok occurs.

## Timing
- Write to readable: a word pushed at edge N can be popped at edge N+1 at the earliest. EMPTY deasserts after edge N.
- Pop latency: one cycle. DATA_OUT is valid after the edge at which pop_ok occurred.
- FULL, EMPTY and COUNT reflect all operations through the last edge. Upstream logic samples them combinationally before asserting PUSH/POP.
- Throughput: one push and one pop per cycle sustained when 0 < COUNT < DEPTH.

## Configuration
- Macro `QUEUE_ERR_EN`.
- Defined:
  - ERR is set on any cycle with PUSH & FULL, or POP & EMPTY.
  - ERR is cleared only by RST.
  - PUSH+POP while FULL counts as an overflow. PUSH+POP while EMPTY counts as an underflow.
- Undefined: the ERR port remains but is tied to 0, and no error logic is synthesized.

## Test plan
All scenarios use DATA_WIDTH=8 and DEPTH=4.
- Fill and drain: after reset, push 0x11, 0x22, 0x33, 0x44, then pop four times.
  - FULL=1 and COUNT=4 after the 4th push.
  - DATA_OUT is 0x11, 0x22, 0x33, 0x44 on successive cycles; EMPTY=1 after the 4th pop.
- Wrap-around: run 10 alternating single push/pop pairs with values 0x00..0x09.
  - Each pop returns the matching value.
  - COUNT stays in 0..1; pointers wrap twice.
- Simultaneous push and pop:
  - With COUNT=2 (0xA0, 0xA1), PUSH 0xB0 and POP together: DATA_OUT=0xA0, COUNT=2; later pops return 0xA1, then 0xB0.
  - When FULL, PUSH 0xFF and POP together: COUNT=3, and 0xFF is never read back.
- Empty boundary: POP on an empty queue.
  - DATA_OUT unchanged; COUNT=0.
  - ERR=1 with `QUEUE_ERR_EN` defined; ERR=0 without it.
- Overflow: a 5th PUSH of 0x55 while full.
  - COUNT stays 4; the drain returns 0x11..0x44 only.
  - ERR stays set until RST.
- Reset mid-operation: with COUNT=3, assert RST together with PUSH.
  - Next cycle: COUNT=0, EMPTY=1, FULL=0, DATA_OUT=0x00, ERR=0.
  - The next push/pop returns the newly pushed word.
